pipe_ctrl: RTL and testbench

//  Consumes the hazard unit's pc_pause / pipe_pause / pipe_bubble controls and owns the
//  PC register plus the four pipeline-register control sets (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_ctrl_pkg.sv | 42 ++++
 rtl/pipe_ctrl_if.sv | 45 ++++
 rtl/pipe_ctrl_pipe_reg.sv | 55 +++++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the pipeline controller and the hazard unit that
//   drives it: NOP encoding, stage bit indices of the pause/bubble vectors,
//   canned control patterns and the per-register operation decode.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int          XLEN_DEF  = 32;
    localparam int          CNT_W     = 32;
    localparam int          NUM_STG   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    // Bit positions inside pipe_pause / pipe_bubble.
    localparam int STG_IFID  = 3;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 1;
    localparam int STG_MEMWB = 0;

    typedef logic [NUM_STG-1:0] stg_mask_t;

    // Patterns the hazard unit emits; both ends agree on the mapping here.
    localparam stg_mask_t PAUSE_NONE      = 4'b0000;
    localparam stg_mask_t BUBBLE_NONE     = 4'b0000;
    localparam stg_mask_t PAUSE_LOAD_USE  = 4'b1000;
    localparam stg_mask_t BUBBLE_LOAD_USE = 4'b0100;
    localparam stg_mask_t BUBBLE_REDIRECT = 4'b1100;

    typedef enum logic [1:0] {
        REG_ADVANCE = 2'd0,
        REG_HOLD    = 2'd1,
        REG_BUBBLE  = 2'd2
    } reg_op_t;

    // Bubble beats pause beats advance.
    function automatic reg_op_t reg_op(input logic pause, input logic bubble);
        if (bubble)     return REG_BUBBLE;
        else if (pause) return REG_HOLD;
        else            return REG_ADVANCE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
//   Bundle between the hazard unit / fetch side (master) and pipe_ctrl (slave).
//   master drives: pc_pause, pipe_pause, pipe_bubble, redirect, redirect_pc,
//                  fetch_instr
//   slave drives : if_pc, {id,ex,mem,wb}_{valid,pc,instr}, stall_cnt,
//                  flush_cnt, proto_err
// -----------------------------------------------------------------------------
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic             pc_pause;
    stg_mask_t        pipe_pause;
    stg_mask_t        pipe_bubble;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [XLEN-1:0]  fetch_instr;

    logic [XLEN-1:0]  if_pc;
    logic             id_valid,  ex_valid,  mem_valid,  wb_valid;
    logic [XLEN-1:0]  id_pc,     ex_pc,     mem_pc,     wb_pc;
    logic [XLEN-1:0]  id_instr,  ex_instr,  mem_instr,  wb_instr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             proto_err;

    modport master (
        output pc_pause, pipe_pause, pipe_bubble, redirect, redirect_pc, fetch_instr,
        input  if_pc,
        input  id_valid, id_pc, id_instr, ex_valid, ex_pc, ex_instr,
        input  mem_valid, mem_pc, mem_instr, wb_valid, wb_pc, wb_instr,
        input  stall_cnt, flush_cnt, proto_err
    );

    modport slave (
        input  pc_pause, pipe_pause, pipe_bubble, redirect, redirect_pc, fetch_instr,
        output if_pc,
        output id_valid, id_pc, id_instr, ex_valid, ex_pc, ex_instr,
        output mem_valid, mem_pc, mem_instr, wb_valid, wb_pc, wb_instr,
        output stall_cnt, flush_cnt, proto_err
    );

endinterface

// File: rtl/pipe_ctrl_pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
//   One pipeline-register control set (valid / pc / instr).
//   clk, rst         : clock, synchronous active-high reset
//   pause, bubble    : hold / NOP-insert for this register (bubble wins)
//   in_valid/pc/instr: values offered by the upstream stage
//   valid/pc/instr   : registered outputs
// -----------------------------------------------------------------------------
module pipe_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int              XLEN = XLEN_DEF,
    parameter logic [XLEN-1:0] NOP  = XLEN'(NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pause,
    input  logic            bubble,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    // NOTE: non-blocking assignments, so every register in the chain samples
    // its neighbour's pre-edge value and the pipeline shifts by exactly one.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP;
        end else begin
            case (reg_op(pause, bubble))
                REG_BUBBLE: begin
                    valid <= 1'b0;
                    pc    <= '0;
                    instr <= NOP;
                end
                REG_HOLD: begin
                    valid <= valid;
                    pc    <= pc;
                    instr <= instr;
                end
                default: begin
                    valid <= in_valid;
                    pc    <= in_pc;
                    instr <= in_instr;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Owns the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB control sets, driven by
//   the hazard unit's pause/bubble/redirect controls. Keeps stall and flush
//   cycle counters and a sticky flag for illegal control combinations.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_ctrl_if.slave (controls and fetch data in; PC, stage
//              registers, counters and proto_err out)
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = XLEN'(NOP_INSTR)
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_next;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             proto_err_q;
    logic             err_now;

    // Stage state, indexed by the same bit numbering as pipe_pause.
    logic [NUM_STG-1:0] stg_valid;
    logic [XLEN-1:0]    stg_pc    [NUM_STG];
    logic [XLEN-1:0]    stg_instr [NUM_STG];

    // ---------------------------------------------------------------- PC
    // NOTE: pc_next gets its default before any condition, so every path
    // assigns it and no latch is inferred.
    always_comb begin
        pc_next = pc_q + XLEN'(4);
        if (bus.redirect)      pc_next = bus.redirect_pc;   // beats pc_pause
        else if (bus.pc_pause) pc_next = pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_next;
    end

    // ----------------------------------------------------- stage registers
    for (genvar b = 0; b < NUM_STG; b++) begin : g_stg
        logic            up_valid;
        logic [XLEN-1:0] up_pc;
        logic [XLEN-1:0] up_instr;

        if (b == STG_IFID) begin : g_src_fetch
            assign up_valid = 1'b1;
            assign up_pc    = pc_q;
            assign up_instr = bus.fetch_instr;
        end else begin : g_src_stage
            assign up_valid = stg_valid[b+1];
            assign up_pc    = stg_pc[b+1];
            assign up_instr = stg_instr[b+1];
        end

        pipe_reg #(
            .XLEN (XLEN),
            .NOP  (NOP)
        ) u_reg (
            .clk      (clk),
            .rst      (rst),
            .pause    (bus.pipe_pause[b]),
            .bubble   (bus.pipe_bubble[b]),
            .in_valid (up_valid),
            .in_pc    (up_pc),
            .in_instr (up_instr),
            .valid    (stg_valid[b]),
            .pc       (stg_pc[b]),
            .instr    (stg_instr[b])
        );
    end

    // ------------------------------------------------------ protocol check
    // Upstream of IF/ID is the PC itself; downstream of MEM/WB is retirement,
    // which can never back-pressure, so that position is always treated as ok.
    stg_mask_t up_hold;
    stg_mask_t dn_ok;

    assign up_hold = {bus.pc_pause, bus.pipe_pause[NUM_STG-1:1]};
    assign dn_ok   = {bus.pipe_pause[NUM_STG-2:0] | bus.pipe_bubble[NUM_STG-2:0], 1'b1};

    assign err_now = (|(bus.pipe_pause & bus.pipe_bubble))             // conflicting controls
                   | (|(bus.pipe_pause & ~up_hold))                    // upstream overruns held reg
                   | (|(bus.pipe_pause & ~dn_ok))                      // held reg issued twice
                   | (bus.redirect &
                      ~(bus.pipe_bubble[STG_IFID] & bus.pipe_bubble[STG_IDEX]));  // wrong-path leak

    // ------------------------------------------------ counters and sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (bus.pc_pause) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (bus.redirect) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            proto_err_q <= proto_err_q | err_now;
        end
    end

    // ------------------------------------------------------------- outputs
    assign bus.if_pc     = pc_q;
    assign bus.id_valid  = stg_valid[STG_IFID];
    assign bus.id_pc     = stg_pc[STG_IFID];
    assign bus.id_instr  = stg_instr[STG_IFID];
    assign bus.ex_valid  = stg_valid[STG_IDEX];
    assign bus.ex_pc     = stg_pc[STG_IDEX];
    assign bus.ex_instr  = stg_instr[STG_IDEX];
    assign bus.mem_valid = stg_valid[STG_EXMEM];
    assign bus.mem_pc    = stg_pc[STG_EXMEM];
    assign bus.mem_instr = stg_instr[STG_EXMEM];
    assign bus.wb_valid  = stg_valid[STG_MEMWB];
    assign bus.wb_pc     = stg_pc[STG_MEMWB];
    assign bus.wb_instr  = stg_instr[STG_MEMWB];
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed scenarios followed by randomized control traffic, all checked
//   against a behavioural model of the pipeline kept as plain arrays indexed
//   by pipeline position (0 = IF/ID .. 3 = MEM/WB).
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [31:0] NOPI = 32'h0000_0013;
    localparam logic [31:0] TAG  = 32'hF000_0000;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.XLEN(32)) bus ();

    pipe_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .NOP      (NOPI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit rand_fetch  = 1'b0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_v [4];
    logic [31:0] m_p [4];
    logic [31:0] m_i [4];
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pcp, input logic [3:0] pz, input logic [3:0] bz,
                         input logic redir, input logic [31:0] rpc);
        bus.pc_pause    = pcp;
        bus.pipe_pause  = pz;
        bus.pipe_bubble = bz;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
    endtask

    // Next state of the pipeline from the current model state and inputs.
    task automatic model_step();
        logic        ov [4];
        logic [31:0] op [4];
        logic [31:0] oi [4];
        logic [3:0]  pz;
        logic [3:0]  bz;
        logic        bad;
        logic        up;
        int          b;
        pz = bus.pipe_pause;
        bz = bus.pipe_bubble;
        if (rst) begin
            m_pc = 32'h0; m_stall = 0; m_flush = 0; m_err = 1'b0;
            for (int p = 0; p < 4; p++) begin
                m_v[p] = 1'b0; m_p[p] = 32'h0; m_i[p] = NOPI;
            end
        end else begin
            bad = bus.redirect && !(bz[3] && bz[2]);
            for (int p = 0; p < 4; p++) begin
                b = 3 - p;
                if (pz[b] && bz[b]) bad = 1'b1;
                if (p == 0) up = bus.pc_pause;
                else        up = pz[b+1];
                if (pz[b] && !up) bad = 1'b1;
                if (p < 3) begin
                    if (pz[b] && !pz[b-1] && !bz[b-1]) bad = 1'b1;
                end
            end
            ov = m_v; op = m_p; oi = m_i;
            for (int p = 0; p < 4; p++) begin
                b = 3 - p;
                if (bz[b]) begin
                    m_v[p] = 1'b0; m_p[p] = 32'h0; m_i[p] = NOPI;
                end else if (!pz[b]) begin
                    if (p == 0) begin
                        m_v[p] = 1'b1; m_p[p] = m_pc; m_i[p] = bus.fetch_instr;
                    end else begin
                        m_v[p] = ov[p-1]; m_p[p] = op[p-1]; m_i[p] = oi[p-1];
                    end
                end
            end
            if (bus.redirect)      m_pc = bus.redirect_pc;
            else if (!bus.pc_pause) m_pc = m_pc + 32'd4;
            if (bus.pc_pause) m_stall = m_stall + 32'd1;
            if (bus.redirect) m_flush = m_flush + 32'd1;
            m_err = m_err | bad;
        end
    endtask

    task automatic compare_all();
        check("if_pc",     bus.if_pc,            m_pc);
        check("id_valid",  32'(bus.id_valid),    32'(m_v[0]));
        check("id_pc",     bus.id_pc,            m_p[0]);
        check("id_instr",  bus.id_instr,         m_i[0]);
        check("ex_valid",  32'(bus.ex_valid),    32'(m_v[1]));
        check("ex_pc",     bus.ex_pc,            m_p[1]);
        check("ex_instr",  bus.ex_instr,         m_i[1]);
        check("mem_valid", 32'(bus.mem_valid),   32'(m_v[2]));
        check("mem_pc",    bus.mem_pc,           m_p[2]);
        check("mem_instr", bus.mem_instr,        m_i[2]);
        check("wb_valid",  32'(bus.wb_valid),    32'(m_v[3]));
        check("wb_pc",     bus.wb_pc,            m_p[3]);
        check("wb_instr",  bus.wb_instr,         m_i[3]);
        check("stall_cnt", bus.stall_cnt,        m_stall);
        check("flush_cnt", bus.flush_cnt,        m_flush);
        check("proto_err", 32'(bus.proto_err),   32'(m_err));
    endtask

    // One clock: present fetch data, advance the model, let the edge pass,
    // then compare every output 1 ns later.
    task automatic tick();
        bus.fetch_instr = rand_fetch ? $urandom : (TAG | m_pc);
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, PAUSE_NONE, BUBBLE_NONE, 1'b0, 32'h0);
        bus.fetch_instr = 32'h0;
        m_pc = 32'h0;
        tick();
        tick();
        // Reset state, explicit constants.
        check("rst_if_pc",     bus.if_pc, 32'h0);
        check("rst_wb_valid",  32'(bus.wb_valid), 32'h0);
        check("rst_id_instr",  bus.id_instr, NOPI);
        check("rst_stall_cnt", bus.stall_cnt, 32'h0);
        rst = 1'b0;

        // Free run: first fetch (pc 0) retires after four edges.
        tick(); tick(); tick(); tick();
        check("run_wb_pc0",   bus.wb_pc, 32'h0);
        check("run_wb_v0",    32'(bus.wb_valid), 32'h1);
        check("run_wb_instr", bus.wb_instr, TAG | 32'h0);
        tick();
        check("run_wb_pc4", bus.wb_pc, 32'h4);
        tick();
        check("run_wb_pc8", bus.wb_pc, 32'h8);
        check("run_if_pc",  bus.if_pc, 32'd24);

        // Load-use stall.
        drive(1'b1, PAUSE_LOAD_USE, BUBBLE_LOAD_USE, 1'b0, 32'h0);
        tick();
        check("lu_if_pc_held", bus.if_pc, 32'd24);
        check("lu_id_pc_held", bus.id_pc, 32'd20);
        check("lu_ex_valid",   32'(bus.ex_valid), 32'h0);
        check("lu_ex_instr",   bus.ex_instr, NOPI);
        check("lu_wb_pc",      bus.wb_pc, 32'd12);
        check("lu_stall_cnt",  bus.stall_cnt, 32'd1);
        drive(1'b0, PAUSE_NONE, BUBBLE_NONE, 1'b0, 32'h0);
        tick();
        check("lu_if_pc_go", bus.if_pc, 32'd28);
        check("lu_wb_pc16",  bus.wb_pc, 32'd16);
        tick();
        check("lu_wb_bubble", 32'(bus.wb_valid), 32'h0);
        tick();
        check("lu_wb_pc20", bus.wb_pc, 32'd20);

        // Redirect resolved in EX.
        drive(1'b0, PAUSE_NONE, BUBBLE_REDIRECT, 1'b1, 32'h100);
        tick();
        check("rd_if_pc",     bus.if_pc, 32'h100);
        check("rd_id_valid",  32'(bus.id_valid), 32'h0);
        check("rd_ex_valid",  32'(bus.ex_valid), 32'h0);
        check("rd_mem_pc",    bus.mem_pc, 32'd28);
        check("rd_flush_cnt", bus.flush_cnt, 32'd1);
        check("rd_no_err",    32'(bus.proto_err), 32'h0);
        drive(1'b0, PAUSE_NONE, BUBBLE_NONE, 1'b0, 32'h0);
        tick();
        check("rd_wb_pc28", bus.wb_pc, 32'd28);
        tick(); tick();
        check("rd_wb_skip", 32'(bus.wb_valid), 32'h0);
        tick();
        check("rd_wb_target", bus.wb_pc, 32'h100);
        check("rd_wb_tv",     32'(bus.wb_valid), 32'h1);

        // Pause and bubble on the same register: bubble wins, flag sticks.
        drive(1'b0, 4'b0100, 4'b0100, 1'b0, 32'h0);
        tick();
        check("pe_ex_valid", 32'(bus.ex_valid), 32'h0);
        check("pe_err",      32'(bus.proto_err), 32'h1);
        drive(1'b0, PAUSE_NONE, BUBBLE_NONE, 1'b0, 32'h0);
        tick(); tick();
        check("pe_err_sticky", 32'(bus.proto_err), 32'h1);

        // Reset during a load-use stall.
        drive(1'b1, PAUSE_LOAD_USE, BUBBLE_LOAD_USE, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        check("mr_if_pc",  bus.if_pc, 32'h0);
        check("mr_id_v",   32'(bus.id_valid), 32'h0);
        check("mr_wb_v",   32'(bus.wb_valid), 32'h0);
        check("mr_stall",  bus.stall_cnt, 32'h0);
        check("mr_flush",  bus.flush_cnt, 32'h0);
        check("mr_err",    32'(bus.proto_err), 32'h0);
        rst = 1'b0;
        drive(1'b0, PAUSE_NONE, BUBBLE_NONE, 1'b0, 32'h0);
        tick(); tick();

        // Counter wrap: preload the stall counter just below the top.
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_stall = 32'hFFFF_FFFE;
        drive(1'b1, PAUSE_LOAD_USE, BUBBLE_LOAD_USE, 1'b0, 32'h0);
        tick();
        check("wr_max", bus.stall_cnt, 32'hFFFF_FFFF);
        tick();
        check("wr_zero", bus.stall_cnt, 32'h0);
        check("wr_err",  32'(bus.proto_err), 32'h0);
        drive(1'b0, PAUSE_NONE, BUBBLE_NONE, 1'b0, 32'h0);
        tick();

        // Randomized traffic: mostly legal hazard-unit patterns, some noise.
        rand_fetch = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 3))
                0: drive(1'b0, PAUSE_NONE, BUBBLE_NONE, 1'b0, 32'h0);
                1: drive(1'b1, PAUSE_LOAD_USE, BUBBLE_LOAD_USE, 1'b0, 32'h0);
                2: drive(1'b0, PAUSE_NONE, BUBBLE_REDIRECT, 1'b1, $urandom & 32'hFFFF_FFFC);
                default: drive(1'($urandom), 4'($urandom), 4'($urandom),
                               1'($urandom), $urandom & 32'hFFFF_FFFC);
            endcase
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
